button_pulser_bank: RTL

BUTTON_PULSER_BANK -- requirements
Module: button_pulser_bank

---
 rtl/button_pulser_bank.sv | 99 +++++++++
 1 files changed

// File: rtl/button_pulser_bank.sv
// button_pulser_bank: per-channel synchronise, debounce, single-step pulse and auto-repeat
module button_pulser_bank #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] one_clock_pulse,
    output logic                any_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PER = RW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          sync1_q, sync2_q, level_q, level_d, pulse_q, pulse_d;
        logic [DW-1:0] db_cnt_q, db_cnt_d;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
        state_t        state_q, state_d;

        assign rep_inc = rep_cnt_q + 1'b1;

        // Debounce: count cycles the synchronised input disagrees with level; toggle on the last one
        always_comb begin
            level_d  = level_q;
            db_cnt_d = '0;
            if (sync2_q != level_q) begin
                if (db_cnt_q == DB_LAST) level_d = ~level_q;
                else db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Step/repeat FSM; next level is used so the pulse registers on the same edge level rises
        always_comb begin
            state_d   = state_q;
            rep_cnt_d = rep_cnt_q;
            pulse_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (level_d && !level_q) begin
                        pulse_d   = 1'b1;
                        state_d   = HELD;
                        rep_cnt_d = '0;
                    end
                end
                default: begin
                    if (!level_d) begin
                        state_d   = IDLE;
                        rep_cnt_d = '0;
                    end else if (repeat_en[i]) begin
                        if (rep_inc == ((state_q == HELD) ? DLY : PER)) begin
                            pulse_d   = 1'b1;
                            rep_cnt_d = '0;
                            state_d   = REPEAT;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
                    end
                end
            endcase
        end

        // All per-channel state, cleared asynchronously
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                level_q   <= 1'b0;
                db_cnt_q  <= '0;
                state_q   <= IDLE;
                rep_cnt_q <= '0;
                pulse_q   <= 1'b0;
            end else begin
                sync1_q   <= button[i];
                sync2_q   <= sync1_q;
                level_q   <= level_d;
                db_cnt_q  <= db_cnt_d;
                state_q   <= state_d;
                rep_cnt_q <= rep_cnt_d;
                pulse_q   <= pulse_d;
            end
        end

        assign level[i]           = level_q;
        assign one_clock_pulse[i] = pulse_q;
    end

    assign any_pulse = |one_clock_pulse;
endmodule
